// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: load-use, long-op RAW/WAW, structural and drain stalls.
// Optional SCOREBOARD_DONE_BYPASS_EN: a completing register is not busy for RAW/WAW checks.
module hazard_scoreboard #(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic [4:0]       id_rs3_addr_i,
  input  logic             id_rs1_fp_i,
  input  logic             id_rs2_fp_i,
  input  logic             id_rs3_fp_i,
  input  logic [2:0]       id_rs_use_i,
  input  logic [4:0]       id_rd_addr_i,
  input  logic             id_rd_wren_I_i,
  input  logic             id_rd_wren_F_i,
  input  logic             id_long_i,
  input  logic             id_drain_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_rd_wren_I_i,
  input  logic             ex_rd_wren_F_i,
  input  logic             lu_ready_i,
  input  logic             lu_done_i,
  input  logic [4:0]       lu_rd_addr_i,
  input  logic             lu_rd_fp_i,
  output logic             stall_o,
  output logic             bubble_o,
  output logic             lu_issue_o,
  output logic [31:0]      busy_I_o,
  output logic [31:0]      busy_F_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  logic [31:0]      busy_i_q, busy_i_d, busy_f_q, busy_f_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             err_q, err_d;

  logic [31:0] done_i_mask, done_f_mask, set_i_mask, set_f_mask;
  logic [31:0] chk_i, chk_f;
  logic [4:0]  rs_addr [3];
  logic [2:0]  rs_fp;
  logic        raw, waw, load_use, structural, drain;
  logic        stray, underflow;

  always_comb begin
    done_i_mask = '0;
    done_f_mask = '0;
    if (lu_done_i) begin
      if (lu_rd_fp_i)                done_f_mask[lu_rd_addr_i] = 1'b1;
      else if (lu_rd_addr_i != 5'd0) done_i_mask[lu_rd_addr_i] = 1'b1;
    end
  end

  // Bit 0 of the integer vector is never set; masking it keeps x0 from ever matching.
`ifdef SCOREBOARD_DONE_BYPASS_EN
  assign chk_i = busy_i_q & ~done_i_mask & ~32'h1;
  assign chk_f = busy_f_q & ~done_f_mask;
`else
  assign chk_i = busy_i_q & ~32'h1;
  assign chk_f = busy_f_q;
`endif

  assign rs_addr[0] = id_rs1_addr_i;
  assign rs_addr[1] = id_rs2_addr_i;
  assign rs_addr[2] = id_rs3_addr_i;
  assign rs_fp      = {id_rs3_fp_i, id_rs2_fp_i, id_rs1_fp_i};

  always_comb begin
    raw      = 1'b0;
    load_use = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (id_rs_use_i[k]) begin
        if (rs_fp[k]) begin
          raw = raw | chk_f[rs_addr[k]];
          if (ex_is_load_i && ex_rd_wren_F_i && (rs_addr[k] == ex_rd_addr_i)) load_use = 1'b1;
        end else begin
          raw = raw | chk_i[rs_addr[k]];
          if (ex_is_load_i && ex_rd_wren_I_i && (ex_rd_addr_i != 5'd0) &&
              (rs_addr[k] == ex_rd_addr_i)) load_use = 1'b1;
        end
      end
    end
  end

  assign waw        = (id_rd_wren_I_i & chk_i[id_rd_addr_i]) |
                      (id_rd_wren_F_i & chk_f[id_rd_addr_i]);
  assign structural = id_long_i & (~lu_ready_i | (pending_q == MaxCnt));
  assign drain      = id_drain_i & (pending_q != '0);

  assign stall_o    = id_valid_i & (raw | waw | load_use | structural | drain);
  assign bubble_o   = stall_o & id_valid_i;
  assign lu_issue_o = id_valid_i & id_long_i & ~stall_o;

  always_comb begin
    set_i_mask = '0;
    set_f_mask = '0;
    if (lu_issue_o) begin
      if (id_rd_wren_I_i && (id_rd_addr_i != 5'd0)) set_i_mask[id_rd_addr_i] = 1'b1;
      if (id_rd_wren_F_i)                           set_f_mask[id_rd_addr_i] = 1'b1;
    end
  end

  // Clear before set so a same-cycle set of the completing register wins.
  assign busy_i_d = (busy_i_q & ~done_i_mask) | set_i_mask;
  assign busy_f_d = (busy_f_q & ~done_f_mask) | set_f_mask;

  assign stray = lu_done_i & ~(lu_rd_fp_i ? busy_f_q[lu_rd_addr_i] : busy_i_q[lu_rd_addr_i]);

  always_comb begin
    pending_d = pending_q;
    underflow = 1'b0;
    unique case ({lu_issue_o, lu_done_i})
      2'b10: pending_d = pending_q + OneCnt;
      2'b01: begin
        if (pending_q == '0) underflow = 1'b1;
        else                 pending_d = pending_q - OneCnt;
      end
      default: pending_d = pending_q;
    endcase
  end

  assign err_d = err_q | stray | underflow;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_i_q  <= '0;
      busy_f_q  <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      busy_i_q  <= busy_i_d;
      busy_f_q  <= busy_f_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign busy_I_o  = busy_i_q;
  assign busy_F_o  = busy_f_q;
  assign pending_o = pending_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard; honours SCOREBOARD_DONE_BYPASS_EN.
module tb_hazard_scoreboard;

  logic        clk_i, rst_ni;
  logic        id_valid_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rs3_addr_i;
  logic        id_rs1_fp_i, id_rs2_fp_i, id_rs3_fp_i;
  logic [2:0]  id_rs_use_i;
  logic [4:0]  id_rd_addr_i;
  logic        id_rd_wren_I_i, id_rd_wren_F_i, id_long_i, id_drain_i;
  logic        ex_is_load_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_rd_wren_I_i, ex_rd_wren_F_i;
  logic        lu_ready_i, lu_done_i;
  logic [4:0]  lu_rd_addr_i;
  logic        lu_rd_fp_i;
  logic        stall_o, bubble_o, lu_issue_o, err_o;
  logic [31:0] busy_I_o, busy_F_o;
  logic [2:0]  pending_o;

  int vectors = 0;
  int miscompares = 0;

`ifdef SCOREBOARD_DONE_BYPASS_EN
  localparam logic StallAtDone = 1'b0;
`else
  localparam logic StallAtDone = 1'b1;
`endif

  hazard_scoreboard #(.MAX_OUT(4), .CNT_W(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rs3_addr_i(id_rs3_addr_i),
    .id_rs1_fp_i(id_rs1_fp_i), .id_rs2_fp_i(id_rs2_fp_i), .id_rs3_fp_i(id_rs3_fp_i),
    .id_rs_use_i(id_rs_use_i), .id_rd_addr_i(id_rd_addr_i),
    .id_rd_wren_I_i(id_rd_wren_I_i), .id_rd_wren_F_i(id_rd_wren_F_i),
    .id_long_i(id_long_i), .id_drain_i(id_drain_i), .ex_is_load_i(ex_is_load_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_wren_I_i(ex_rd_wren_I_i), .ex_rd_wren_F_i(ex_rd_wren_F_i),
    .lu_ready_i(lu_ready_i), .lu_done_i(lu_done_i), .lu_rd_addr_i(lu_rd_addr_i),
    .lu_rd_fp_i(lu_rd_fp_i), .stall_o(stall_o), .bubble_o(bubble_o), .lu_issue_o(lu_issue_o),
    .busy_I_o(busy_I_o), .busy_F_o(busy_F_o), .pending_o(pending_o), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    id_valid_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rs3_addr_i = 0;
    id_rs1_fp_i = 0; id_rs2_fp_i = 0; id_rs3_fp_i = 0; id_rs_use_i = 0; id_rd_addr_i = 0;
    id_rd_wren_I_i = 0; id_rd_wren_F_i = 0; id_long_i = 0; id_drain_i = 0;
    ex_is_load_i = 0; ex_rd_addr_i = 0; ex_rd_wren_I_i = 0; ex_rd_wren_F_i = 0;
    lu_ready_i = 1; lu_done_i = 0; lu_rd_addr_i = 0; lu_rd_fp_i = 0;
  endtask

  task automatic pulse_reset();
    rst_ni = 0;
    #1;
    rst_ni = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 0;
    tick(); tick();
    vectors++;
    if ({busy_I_o, busy_F_o, pending_o, err_o, stall_o} !== 70'd0) begin
      $display("FAIL reset_init: got %h/%h/%0d/%b/%b want all zero",
               busy_I_o, busy_F_o, pending_o, err_o, stall_o);
      miscompares++;
    end
    rst_ni = 1;
    tick();
    // fdiv f4, then reset mid-run
    id_valid_i = 1; id_long_i = 1; id_rd_wren_F_i = 1; id_rd_addr_i = 4;
    tick();
    idle();
    #1;
    vectors++;
    if (busy_F_o !== 32'h0000_0010) begin
      $display("FAIL reset_setup_busyF: got %h want 00000010", busy_F_o);
      miscompares++;
    end
    rst_ni = 0;
    #1;
    vectors++;
    if ({busy_I_o, busy_F_o, pending_o, err_o, stall_o} !== 70'd0) begin
      $display("FAIL reset_async: got %h/%h/%0d/%b/%b want all zero",
               busy_I_o, busy_F_o, pending_o, err_o, stall_o);
      miscompares++;
    end
    tick();
    rst_ni = 1;
  endtask

  task automatic test_long_raw();
    idle();
    id_valid_i = 1; id_long_i = 1; id_rd_wren_F_i = 1; id_rd_addr_i = 4;
    #1;
    vectors++;
    if (lu_issue_o !== 1'b1 || stall_o !== 1'b0) begin
      $display("FAIL raw_issue: got issue=%b stall=%b want 1/0", lu_issue_o, stall_o);
      miscompares++;
    end
    tick();
    // cycle 1: fadd f1, f4, f2
    id_long_i = 0; id_rs_use_i = 3'b011; id_rs1_addr_i = 4; id_rs1_fp_i = 1;
    id_rs2_addr_i = 2; id_rs2_fp_i = 1; id_rd_addr_i = 1;
    #1;
    vectors++;
    if (busy_F_o !== 32'h10 || pending_o !== 3'd1 || stall_o !== 1'b1 || bubble_o !== 1'b1) begin
      $display("FAIL raw_cycle1: got busyF=%h pend=%0d stall=%b bubble=%b want 10/1/1/1",
               busy_F_o, pending_o, stall_o, bubble_o);
      miscompares++;
    end
    for (int c = 2; c <= 9; c++) begin
      tick();
      vectors++;
      if (stall_o !== 1'b1) begin
        $display("FAIL raw_hold_c%0d: got stall=%b want 1", c, stall_o);
        miscompares++;
      end
    end
    tick();
    lu_done_i = 1; lu_rd_addr_i = 4; lu_rd_fp_i = 1;
    #1;
    vectors++;
    if (stall_o !== StallAtDone) begin
      $display("FAIL raw_done_cycle: got stall=%b want %b", stall_o, StallAtDone);
      miscompares++;
    end
    tick();
    lu_done_i = 0;
    #1;
    vectors++;
    if (stall_o !== 1'b0 || busy_F_o !== 32'h0 || pending_o !== 3'd0 || err_o !== 1'b0) begin
      $display("FAIL raw_release: got stall=%b busyF=%h pend=%0d err=%b want 0/0/0/0",
               stall_o, busy_F_o, pending_o, err_o);
      miscompares++;
    end
  endtask

  task automatic test_load_use();
    idle();
    // lw x5 in EX, add x6, x5, x1 in ID
    id_valid_i = 1; id_rs_use_i = 3'b011; id_rs1_addr_i = 5; id_rs2_addr_i = 1;
    id_rd_wren_I_i = 1; id_rd_addr_i = 6;
    ex_is_load_i = 1; ex_rd_addr_i = 5; ex_rd_wren_I_i = 1;
    #1;
    vectors++;
    if (stall_o !== 1'b1 || bubble_o !== 1'b1 || lu_issue_o !== 1'b0) begin
      $display("FAIL lu_first: got stall=%b bubble=%b want 1/1", stall_o, bubble_o);
      miscompares++;
    end
    tick();
    ex_is_load_i = 0; ex_rd_wren_I_i = 0;
    #1;
    vectors++;
    if (stall_o !== 1'b0 || bubble_o !== 1'b0) begin
      $display("FAIL lu_second: got stall=%b bubble=%b want 0/0", stall_o, bubble_o);
      miscompares++;
    end
    // load to x0, ID reads x0
    ex_is_load_i = 1; ex_rd_addr_i = 0; ex_rd_wren_I_i = 1; id_rs1_addr_i = 0;
    #1;
    vectors++;
    if (stall_o !== 1'b0) begin
      $display("FAIL lu_x0: got stall=%b want 0", stall_o);
      miscompares++;
    end
    // flw f0, ID reads f0: f0 is a real register
    ex_rd_wren_I_i = 0; ex_rd_wren_F_i = 1; id_rs1_fp_i = 1;
    #1;
    vectors++;
    if (stall_o !== 1'b1) begin
      $display("FAIL lu_f0: got stall=%b want 1", stall_o);
      miscompares++;
    end
    id_valid_i = 0;
    #1;
    vectors++;
    if (stall_o !== 1'b0 || bubble_o !== 1'b0) begin
      $display("FAIL lu_invalid: got stall=%b bubble=%b want 0/0", stall_o, bubble_o);
      miscompares++;
    end
  endtask

  task automatic test_structural_drain();
    idle();
    id_valid_i = 1; id_long_i = 1; id_rd_wren_I_i = 1; id_rd_addr_i = 9; lu_ready_i = 0;
    #1;
    vectors++;
    if (stall_o !== 1'b1 || lu_issue_o !== 1'b0) begin
      $display("FAIL st_not_ready: got stall=%b issue=%b want 1/0", stall_o, lu_issue_o);
      miscompares++;
    end
    lu_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      id_rd_addr_i = 5'(10 + i);
      #1;
      vectors++;
      if (lu_issue_o !== 1'b1) begin
        $display("FAIL st_issue%0d: got issue=%b want 1", i, lu_issue_o);
        miscompares++;
      end
      tick();
    end
    id_rd_addr_i = 14;
    #1;
    vectors++;
    if (pending_o !== 3'd4 || busy_I_o !== 32'h0000_3C00 || stall_o !== 1'b1 || lu_issue_o !== 1'b0) begin
      $display("FAIL st_full: got pend=%0d busyI=%h stall=%b issue=%b want 4/00003c00/1/0",
               pending_o, busy_I_o, stall_o, lu_issue_o);
      miscompares++;
    end
    tick();
    lu_done_i = 1; lu_rd_addr_i = 10;
    #1;
    vectors++;
    if (stall_o !== 1'b1) begin
      $display("FAIL st_done_cycle: got stall=%b want 1", stall_o);
      miscompares++;
    end
    tick();
    // fifth op issues while x11 completes in the same cycle
    lu_rd_addr_i = 11;
    #1;
    vectors++;
    if (pending_o !== 3'd3 || lu_issue_o !== 1'b1) begin
      $display("FAIL st_release: got pend=%0d issue=%b want 3/1", pending_o, lu_issue_o);
      miscompares++;
    end
    tick();
    lu_done_i = 0; id_rd_addr_i = 15;
    #1;
    vectors++;
    if (pending_o !== 3'd3 || busy_I_o !== 32'h0000_7000 || lu_issue_o !== 1'b1) begin
      $display("FAIL st_issue_and_done: got pend=%0d busyI=%h issue=%b want 3/00007000/1",
               pending_o, busy_I_o, lu_issue_o);
      miscompares++;
    end
    tick();
    idle();
    #1;
    vectors++;
    if (pending_o !== 3'd4 || busy_I_o !== 32'h0000_F000) begin
      $display("FAIL st_refill: got pend=%0d busyI=%h want 4/0000f000", pending_o, busy_I_o);
      miscompares++;
    end
    lu_done_i = 1; lu_rd_addr_i = 12;
    tick();
    lu_rd_addr_i = 13;
    tick();
    lu_done_i = 0; id_valid_i = 1; id_drain_i = 1;
    #1;
    vectors++;
    if (pending_o !== 3'd2 || stall_o !== 1'b1) begin
      $display("FAIL drain_start: got pend=%0d stall=%b want 2/1", pending_o, stall_o);
      miscompares++;
    end
    lu_done_i = 1; lu_rd_addr_i = 14;
    tick();
    lu_rd_addr_i = 15;
    #1;
    vectors++;
    if (pending_o !== 3'd1 || stall_o !== 1'b1) begin
      $display("FAIL drain_mid: got pend=%0d stall=%b want 1/1", pending_o, stall_o);
      miscompares++;
    end
    tick();
    lu_done_i = 0;
    #1;
    vectors++;
    if (pending_o !== 3'd0 || stall_o !== 1'b0 || busy_I_o !== 32'h0 || err_o !== 1'b0) begin
      $display("FAIL drain_end: got pend=%0d stall=%b busyI=%h err=%b want 0/0/0/0",
               pending_o, stall_o, busy_I_o, err_o);
      miscompares++;
    end
  endtask

  task automatic test_errors();
    idle();
    pulse_reset();
    lu_done_i = 1; lu_rd_addr_i = 7;
    #1;
    vectors++;
    if (err_o !== 1'b0) begin
      $display("FAIL err_before_edge: got err=%b want 0", err_o);
      miscompares++;
    end
    tick();
    lu_done_i = 1; lu_rd_addr_i = 3; lu_rd_fp_i = 1;
    tick();
    lu_done_i = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (err_o !== 1'b1 || busy_I_o !== 32'h0 || busy_F_o !== 32'h0 || pending_o !== 3'd0) begin
        $display("FAIL err_sticky%0d: got err=%b busyI=%h busyF=%h pend=%0d want 1/0/0/0",
                 c, err_o, busy_I_o, busy_F_o, pending_o);
        miscompares++;
      end
    end
    // stray completion with an op genuinely in flight
    idle();
    pulse_reset();
    id_valid_i = 1; id_long_i = 1; id_rd_wren_I_i = 1; id_rd_addr_i = 20;
    tick();
    id_long_i = 0;
    #1;
    vectors++;
    if (stall_o !== 1'b1) begin
      $display("FAIL waw_x20: got stall=%b want 1", stall_o);
      miscompares++;
    end
    id_valid_i = 0; lu_done_i = 1; lu_rd_addr_i = 7;
    tick();
    lu_done_i = 0;
    #1;
    vectors++;
    if (err_o !== 1'b1 || busy_I_o !== 32'h0010_0000) begin
      $display("FAIL err_stray: got err=%b busyI=%h want 1/00100000", err_o, busy_I_o);
      miscompares++;
    end
    // long op writing x0 is counted but sets no busy bit
    idle();
    pulse_reset();
    id_valid_i = 1; id_long_i = 1; id_rd_wren_I_i = 1; id_rd_addr_i = 0;
    tick();
    idle();
    #1;
    vectors++;
    if (busy_I_o !== 32'h0 || pending_o !== 3'd1 || err_o !== 1'b0) begin
      $display("FAIL issue_x0: got busyI=%h pend=%0d err=%b want 0/1/0",
               busy_I_o, pending_o, err_o);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_long_raw();
    test_load_use();
    test_structural_drain();
    test_errors();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
